// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcodes, controller states, flag positions and
// register-field decode for the ALU issue controller.
package alu_issue_ctrl_pkg;

   typedef enum logic [2:0] {
      kADD = 3'd0,
      kLSL = 3'd1,
      kXOR = 3'd2,
      kAND = 3'd3,
      kCMP = 3'd4,
      kSET = 3'd5,
      kLSR = 3'd6,
      kSUB = 3'd7
   } op_mne_e;

   typedef enum logic [1:0] {
      kMOVE  = 2'd0,
      kFLAG  = 2'd1,
      kLOAD  = 2'd2,
      kSTORE = 2'd3
   } data_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MEM  = 2'd2
   } ctrl_state_e;

   localparam int FL_SC     = 4;
   localparam int FL_ZERO   = 3;
   localparam int FL_BEVEN  = 2;
   localparam int FL_PARITY = 1;
   localparam int FL_EQUAL  = 0;

   function automatic logic [2:0] dec_rd(input logic [8:0] ir);
      return ir[8] ? ir[5:3] : ir[4:2];
   endfunction

   // Arithmetic form only reaches R0..R3 as a source.
   function automatic logic [2:0] dec_rs(input logic [8:0] ir);
      return ir[8] ? ir[2:0] : {1'b0, ir[1:0]};
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// 8x8 register file: two operand read ports, a debug read port
// and one synchronous write port with synchronous clear.
module alu_issue_ctrl_reg_file (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we,
   input  logic [2:0] waddr,
   input  logic [7:0] wdata,
   input  logic [2:0] ra0,
   input  logic [2:0] ra1,
   input  logic [2:0] dbg_addr,
   output logic [7:0] rd0,
   output logic [7:0] rd1,
   output logic [7:0] dbg_data
);

   logic [7:0] regs [8];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rd0      = regs[ra0];
   assign rd1      = regs[ra1];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: instruction handshake,
// register write-back, flag latching and LOAD/STORE sequencing.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TW          = 8
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       instr_valid,
   input  logic [8:0] instr,
   output logic       instr_ready,
   output logic [7:0] ALU_arg_0,
   output logic [7:0] ALU_arg_1,
   output logic [2:0] ALU_op_code,
   output logic [1:0] Data_op_code,
   output logic       Data_signifier,
   output logic       SC_IN,
   input  logic [7:0] ALU_out,
   input  logic       SC_OUT,
   input  logic       ZERO,
   input  logic       BEVEN,
   input  logic       PARITY,
   input  logic       EQUAL,
   output logic [4:0] flags,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       mem_err,
   output logic       done,
   input  logic [2:0] dbg_addr,
   output logic [7:0] dbg_data
);

   ctrl_state_e   state;
   logic [8:0]    ir;
   logic [4:0]    flags_q;
   logic [TW-1:0] cnt;
   logic          done_q;
   logic          err_q;

   logic [2:0] rd;
   logic [2:0] rs;
   logic [7:0] rd_val;
   logic [7:0] rs_val;
   logic       we;
   logic [7:0] wdata;
   logic [4:0] alu_flags;
   logic       busy;
   logic       is_data;
   op_mne_e    op;
   data_op_e   dop;

   assign rd        = dec_rd(ir);
   assign rs        = dec_rs(ir);
   assign is_data   = ir[8];
   assign op        = op_mne_e'(ir[7:5]);
   assign dop       = data_op_e'(ir[7:6]);
   assign busy      = (state != IDLE);
   assign alu_flags = {SC_OUT, ZERO, BEVEN, PARITY, EQUAL};

   alu_issue_ctrl_reg_file u_rf (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .we       (we),
      .waddr    (rd),
      .wdata    (wdata),
      .ra0      (rd),
      .ra1      (rs),
      .dbg_addr (dbg_addr),
      .rd0      (rd_val),
      .rd1      (rs_val),
      .dbg_data (dbg_data)
   );

   always_comb begin
      we    = 1'b0;
      wdata = ALU_out;
      unique case (1'b1)
         (state == EXEC) && !is_data: begin
            we = (op != kCMP);
         end
         (state == EXEC) && is_data: begin
            we = (dop == kMOVE) || (dop == kFLAG);
         end
         (state == MEM): begin
            we    = mem_ack && (dop == kLOAD);
            wdata = mem_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state   <= IDLE;
         ir      <= '0;
         flags_q <= '0;
         cnt     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (is_data && ir[7]) begin
                  state <= MEM;
               end else begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  if (!is_data) flags_q <= alu_flags;
               end
            end
            MEM: begin
               // A late ack still completes the access normally.
               if (mem_ack) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  cnt    <= '0;
               end else if (cnt == TW'(MEM_TIMEOUT - 1)) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign instr_ready    = Reset_n && (state == IDLE);
   assign ALU_arg_0      = busy ? rd_val : '0;
   assign ALU_arg_1      = busy ? rs_val : '0;
   assign ALU_op_code    = busy ? ir[7:5] : '0;
   assign Data_op_code   = busy ? ir[7:6] : '0;
   assign Data_signifier = busy && ir[8];
   assign SC_IN          = flags_q[FL_SC];
   assign flags          = flags_q;
   assign mem_req        = (state == MEM);
   assign mem_we         = mem_req && (dop == kSTORE);
   assign mem_addr       = mem_req ? rs_val : '0;
   assign mem_wdata      = mem_req ? rd_val : '0;
   assign mem_err        = err_q;
   assign done           = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU,
// a latency-controlled data memory and an instruction-level model.
module tb_alu_issue_ctrl;

   localparam int MEM_TIMEOUT = 15;

   logic       Clk;
   logic       Reset_n;
   logic       instr_valid;
   logic [8:0] instr;
   logic       instr_ready;
   logic [7:0] ALU_arg_0;
   logic [7:0] ALU_arg_1;
   logic [2:0] ALU_op_code;
   logic [1:0] Data_op_code;
   logic       Data_signifier;
   logic       SC_IN;
   logic [7:0] ALU_out;
   logic       SC_OUT;
   logic       ZERO;
   logic       BEVEN;
   logic       PARITY;
   logic       EQUAL;
   logic [4:0] flags;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic       mem_err;
   logic       done;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;

   alu_issue_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TW(8)) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_ready    (instr_ready),
      .ALU_arg_0      (ALU_arg_0),
      .ALU_arg_1      (ALU_arg_1),
      .ALU_op_code    (ALU_op_code),
      .Data_op_code   (Data_op_code),
      .Data_signifier (Data_signifier),
      .SC_IN          (SC_IN),
      .ALU_out        (ALU_out),
      .SC_OUT         (SC_OUT),
      .ZERO           (ZERO),
      .BEVEN          (BEVEN),
      .PARITY         (PARITY),
      .EQUAL          (EQUAL),
      .flags          (flags),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .mem_err        (mem_err),
      .done           (done),
      .dbg_addr       (dbg_addr),
      .dbg_data       (dbg_data)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Returns {SC,ZERO,BEVEN,PARITY,EQUAL,result}.
   function automatic logic [12:0] alu_fn(input logic [8:0] ins,
                                          input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic sc);
      logic [8:0] t;
      logic [7:0] r;
      logic       c;
      c = 1'b0;
      r = 8'h00;
      t = 9'h000;
      if (!ins[8]) begin
         case (ins[7:5])
            3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
            3'd1: begin r = a << 1; c = a[7]; end
            3'd2: r = a ^ b;
            3'd3: r = a & b;
            3'd4, 3'd7: begin r = a - b; c = (a < b); end
            3'd5: r = a | (8'h01 << b[2:0]);
            default: begin r = a >> 1; c = a[0]; end
         endcase
      end else begin
         case (ins[7:6])
            2'd0: r = b;
            2'd1: r = {7'b0, sc};
            default: r = 8'h00;
         endcase
      end
      return {c, (r == 8'h00), ~r[0], ^r, (a == b), r};
   endfunction

   logic [8:0]  alu_ins;
   logic [12:0] alu_o;
   always_comb begin
      alu_ins = Data_signifier ? {1'b1, Data_op_code, 6'b0}
                               : {1'b0, ALU_op_code, 5'b0};
      alu_o   = alu_fn(alu_ins, ALU_arg_0, ALU_arg_1, SC_IN);
   end
   assign ALU_out = alu_o[7:0];
   assign {SC_OUT, ZERO, BEVEN, PARITY, EQUAL} = alu_o[12:8];

   function automatic logic [7:0] mem_init_val(input int i);
      case (i)
         0:       return 8'h05;
         3:       return 8'h20;
         5:       return 8'h03;
         32:      return 8'hA5;
         default: return 8'(i * 37 + 11);
      endcase
   endfunction

   logic [7:0] mem [256];
   int  mem_lat    = 0;
   bit  mem_ack_en = 1'b1;
   int  req_cycles = 0;
   bit  mem_inited = 1'b0;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
   end

   always @(negedge Clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < 256; i++) mem[i] = mem_init_val(i);
         mem_inited = 1'b1;
      end
      mem_ack = 1'b0;
      if (mem_req) begin
         if (mem_ack_en && req_cycles == mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
         end
         req_cycles++;
      end else begin
         req_cycles = 0;
      end
   end

   logic [7:0] m_r [8];
   logic [4:0] m_flags;
   logic       m_err;
   logic [7:0] m_mem [256];

   function automatic logic [2:0] f_rd(input logic [8:0] ins);
      return ins[8] ? ins[5:3] : ins[4:2];
   endfunction

   function automatic logic [2:0] f_rs(input logic [8:0] ins);
      return ins[8] ? ins[2:0] : {1'b0, ins[1:0]};
   endfunction

   function automatic logic [8:0] f_ar(input int op, input int rd, input int rs);
      return {1'b0, 3'(op), 3'(rd), 2'(rs)};
   endfunction

   function automatic logic [8:0] f_da(input int op, input int rd, input int rs);
      return {1'b1, 2'(op), 3'(rd), 3'(rs)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
      m_flags = 5'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_step(input logic [8:0] ins);
      logic [2:0]  rd;
      logic [2:0]  rs;
      logic [12:0] o;
      rd = f_rd(ins);
      rs = f_rs(ins);
      o  = alu_fn(ins, m_r[rd], m_r[rs], m_flags[4]);
      if (!ins[8]) begin
         if (ins[7:5] != 3'd4) m_r[rd] = o[7:0];
         m_flags = o[12:8];
      end else if (!ins[7]) begin
         m_r[rd] = o[7:0];
      end else if (mem_ack_en && mem_lat < MEM_TIMEOUT) begin
         if (ins[6]) m_mem[m_r[rs]] = m_r[rd];
         else        m_r[rd] = m_mem[m_r[rs]];
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk($sformatf("r%0d", i), dbg_data, m_r[i]);
      end
      chk("flags", flags, m_flags);
      chk("mem_err", mem_err, m_err);
   endtask

   task automatic run(input logic [8:0] ins, output int nreq);
      int         k;
      int         nbusy;
      int         exp_req;
      logic [7:0] a_seen;
      logic [7:0] w_seen;
      logic       we_seen;
      logic       stable;
      logic       is_mem;
      logic       ok;
      is_mem  = ins[8] & ins[7];
      ok      = mem_ack_en && (mem_lat < MEM_TIMEOUT);
      exp_req = !is_mem ? 0 : (ok ? mem_lat + 1 : MEM_TIMEOUT);
      nreq    = 0;
      nbusy   = 0;
      a_seen  = 8'h00;
      w_seen  = 8'h00;
      we_seen = 1'b0;
      stable  = 1'b1;
      k = 0;
      while (!instr_ready && k < 40) begin
         tick();
         k++;
      end
      chk("ready_wait", instr_ready, 1);
      instr       = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      k = 0;
      while (!done && k < 300) begin
         if (!instr_ready) nbusy++;
         if (mem_req) begin
            if (nreq > 0 && mem_addr != a_seen) stable = 1'b0;
            nreq++;
            a_seen  = mem_addr;
            w_seen  = mem_wdata;
            we_seen = mem_we;
         end
         tick();
         k++;
      end
      chk("done_seen", done, 1);
      chk("req_cycles", nreq, exp_req);
      chk("busy_cycles", nbusy, exp_req + 1);
      if (is_mem) begin
         chk("mem_addr", a_seen, m_r[f_rs(ins)]);
         chk("mem_addr_stable", stable, 1);
         chk("mem_we", we_seen, ins[6]);
         if (ins[6]) chk("mem_wdata", w_seen, m_r[f_rd(ins)]);
      end
      model_step(ins);
      compare_all();
      tick();
      chk("done_pulse", done, 0);
   endtask

   typedef struct {
      logic [8:0] ins;
      int         lat;
      logic [7:0] exp_val;
      logic [4:0] exp_fl;
   } vec_t;

   vec_t       tbl [13];
   int         nr;
   int         p;
   logic [8:0] rins;
   logic [8:0] q [4];
   int         acc [4];
   int         idx;
   int         dn;
   int         cyc;
   bit         accept;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{f_da(2, 1, 0), 1, 8'h05, 5'b00000};
      tbl[1]  = '{f_da(2, 2, 1), 1, 8'h03, 5'b00000};
      tbl[2]  = '{f_da(2, 3, 2), 1, 8'h20, 5'b00000};
      tbl[3]  = '{f_ar(0, 1, 2), 0, 8'h08, 5'b00110};
      tbl[4]  = '{f_ar(4, 2, 2), 0, 8'h03, 5'b01101};
      tbl[5]  = '{f_da(0, 5, 3), 0, 8'h20, 5'b01101};
      tbl[6]  = '{f_ar(2, 5, 1), 0, 8'h28, 5'b00100};
      tbl[7]  = '{f_ar(7, 1, 3), 0, 8'hE8, 5'b10100};
      tbl[8]  = '{f_da(1, 6, 0), 0, 8'h01, 5'b10100};
      tbl[9]  = '{f_ar(1, 6, 2), 0, 8'h02, 5'b00110};
      tbl[10] = '{f_ar(6, 5, 0), 0, 8'h14, 5'b00100};
      tbl[11] = '{f_ar(3, 5, 1), 0, 8'h00, 5'b01100};
      tbl[12] = '{f_ar(5, 7, 1), 0, 8'h01, 5'b00010};

      for (int i = 0; i < 256; i++) m_mem[i] = mem_init_val(i);
      model_reset();
      Reset_n     = 1'b0;
      instr_valid = 1'b0;
      instr       = 9'h000;
      dbg_addr    = 3'd0;

      repeat (3) tick();
      chk("rst_ready_low", instr_ready, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_done", done, 0);
      Reset_n = 1'b1;
      #1;
      chk("ready_after_rst", instr_ready, 1);
      chk("idle_arg0", ALU_arg_0, 0);
      chk("idle_opcode", ALU_op_code, 0);
      chk("idle_dsig", Data_signifier, 0);
      compare_all();

      for (int i = 0; i < 13; i++) begin
         mem_ack_en = 1'b1;
         mem_lat    = tbl[i].lat;
         run(tbl[i].ins, nr);
         dbg_addr = f_rd(tbl[i].ins);
         #1;
         chk($sformatf("tbl%0d_val", i), dbg_data, tbl[i].exp_val);
         chk($sformatf("tbl%0d_flags", i), flags, tbl[i].exp_fl);
      end

      mem_lat = 3;
      run(f_da(2, 4, 3), nr);
      chk("load_req4", nr, 4);
      dbg_addr = 3'd4;
      #1;
      chk("load_r4", dbg_data, 8'hA5);

      mem_lat = 14;
      run(f_da(2, 7, 0), nr);
      chk("late_ack_req", nr, 15);
      chk("late_ack_err", mem_err, 0);

      mem_ack_en = 1'b0;
      run(f_da(3, 4, 1), nr);
      chk("timeout_req", nr, 15);
      chk("timeout_err", mem_err, 1);
      chk("timeout_nowrite", mem[8'hE8], mem_init_val(232));

      mem_ack_en = 1'b1;
      mem_lat    = 0;
      run(f_da(3, 4, 0), nr);
      chk("store_mem0", mem[0], 8'hA5);
      chk("err_sticky", mem_err, 1);

      for (int i = 0; i < 4; i++) q[i] = f_ar(0, 1, 2);
      idx = 0;
      dn  = 0;
      cyc = 0;
      while ((idx < 4 || dn < 4) && cyc < 60) begin
         if (idx < 4) begin
            instr       = q[idx];
            instr_valid = 1'b1;
         end else begin
            instr_valid = 1'b0;
         end
         accept = (idx < 4) && instr_ready;
         tick();
         cyc++;
         if (accept) begin
            acc[idx] = cyc;
            idx++;
         end
         if (done) dn++;
      end
      instr_valid = 1'b0;
      chk("b2b_accepted", idx, 4);
      chk("b2b_done", dn, 4);
      chk("b2b_gap", acc[1] - acc[0], 2);
      chk("b2b_span", acc[3] - acc[0], 6);
      for (int i = 0; i < 4; i++) model_step(q[i]);
      compare_all();
      dbg_addr = 3'd1;
      #1;
      chk("b2b_r1", dbg_data, 8'hF4);

      mem_ack_en  = 1'b0;
      instr       = f_da(2, 6, 1);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      chk("mid_rst_req", mem_req, 1);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_ready", instr_ready, 0);
      tick();
      chk("mid_rst_req_drop", mem_req, 0);
      chk("mid_rst_done", done, 0);
      model_reset();
      compare_all();
      tick();
      chk("mid_rst_ready2", instr_ready, 0);
      Reset_n = 1'b1;
      #1;
      chk("mid_rst_release", instr_ready, 1);

      for (int n = 0; n < 200; n++) begin
         p          = $urandom_range(0, 99);
         mem_ack_en = (p >= 8);
         mem_lat    = (p < 12) ? 14 + (p & 1) : $urandom_range(0, 4);
         rins       = 9'($urandom);
         run(rins, nr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
